adder_tree_accumulator: RTL and testbench

// - Consumes the result of pipelined_adder_tree and owns that tree's single `advance` enable.
// - Tracks valid/last tags through the tree latency.
// - Accumulates the per-chunk partial sums of one long dot-product vector and emits one saturated total per vector.
// - Output uses a valid/ready handshake towards the custom-unit writeback.

---
 rtl/custom_pkg.sv | 24 ++
 rtl/valid_tag_pipe.sv | 28 ++
 rtl/adder_tree_accumulator.sv | 106 ++++++++++
 tb/tb_adder_tree_accumulator.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_pkg.sv
// Shared types and constants for the custom-unit adder-tree datapath.
package custom_pkg;

    localparam int ADDER_TREE_STAGES = 4;
    localparam int ADDER_TREE_W      = 16;
    localparam int ACC_W_DEF         = 32;

    typedef struct packed {
        logic v;
        logic last;
    } tree_tag_t;

    typedef logic [ACC_W_DEF-1:0] acc_t;

    // Saturating add of an unsigned tree result into a default-width accumulator.
    function automatic acc_t sat_add(input acc_t a, input logic [ADDER_TREE_W-1:0] b,
                                     output logic sat);
        logic [ACC_W_DEF:0] s;
        s   = {1'b0, a} + (ACC_W_DEF+1)'(b);
        sat = s[ACC_W_DEF];
        return sat ? '1 : s[ACC_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/valid_tag_pipe.sv
// Shift register of per-chunk {v,last} tags that tracks the adder-tree latency.
module valid_tag_pipe
    import custom_pkg::*;
#(
    parameter int STAGES = ADDER_TREE_STAGES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      clr,
    input  tree_tag_t tag_in,
    output tree_tag_t tag_out
);

    tree_tag_t tag_p [STAGES];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < STAGES; k++) tag_p[k] <= '0;
        end else if (en) begin
            tag_p[0] <= tag_in;
            for (int k = 1; k < STAGES; k++) tag_p[k] <= tag_p[k-1];
        end
    end

    assign tag_out = tag_p[STAGES-1];

endmodule

// File: rtl/adder_tree_accumulator.sv
// Accumulates adder-tree partial sums per vector and hands one saturated total
// per vector to the writeback over valid/ready.
module adder_tree_accumulator
    import custom_pkg::*;
#(
    parameter int TREE_STAGES = ADDER_TREE_STAGES,
    parameter int TREE_W      = 16,
    parameter int ACC_W       = 32,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tree_advance,
    input  logic [TREE_W-1:0] tree_result,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_chunks,
    output logic              out_sat
);

    logic             advance;
    logic             retire;
    tree_tag_t        tag_in;
    tree_tag_t        tail_tag;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sat_acc;
    logic             sat_nxt;

    function automatic logic [ACC_W-1:0] acc_sat_add(input logic [ACC_W-1:0] a,
                                                     input logic [TREE_W-1:0] b,
                                                     output logic sat);
        logic [ACC_W:0] s;
        s   = {1'b0, a} + (ACC_W+1)'(b);
        sat = s[ACC_W];
        return sat ? '1 : s[ACC_W-1:0];
    endfunction

    // A pending total that nobody takes freezes the tree, the tags and the accumulator together.
    assign advance      = !out_valid || out_ready;
    assign in_ready     = advance;
    assign tree_advance = advance;

    assign tag_in = '{v: in_valid, last: in_last};

    valid_tag_pipe #(
        .STAGES (TREE_STAGES)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .en      (advance),
        .clr     (clear),
        .tag_in  (tag_in),
        .tag_out (tail_tag)
    );

    // Tail tag describes the current tree_result; retire it into the running sum.
    assign retire = tail_tag.v && advance && !clear;

    always_comb begin
        sat_nxt = 1'b0;
        sum_nxt = acc_sat_add(acc, tree_result, sat_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
        end else if (retire) begin
            if (tail_tag.last) begin
                acc     <= '0;
                cnt     <= '0;
                sat_acc <= 1'b0;
            end else begin
                acc     <= sum_nxt;
                cnt     <= cnt + 1'b1;
                sat_acc <= sat_acc | sat_nxt;
            end
        end
    end

    // Output register: a retiring last reloads it even during the handshake cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_chunks <= '0;
            out_sat    <= 1'b0;
        end else if (retire && tail_tag.last) begin
            out_valid  <= 1'b1;
            out_sum    <= sum_nxt;
            out_chunks <= cnt + 1'b1;
            out_sat    <= sat_acc | sat_nxt;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Bench for adder_tree_accumulator driven through a behavioural 16x12-bit adder tree.
module tb_adder_tree_accumulator;

    localparam int TS = 4;
    localparam int TW = 16;
    localparam int AW = 16;
    localparam int CW = 8;
    localparam int NI = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic          tree_advance;
    logic [TW-1:0] tree_result;
    logic          clear = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_chunks;
    logic          out_sat;

    logic [11:0]   elems [NI];
    logic [TW-1:0] chunk_sum;
    logic [TW-1:0] tree_p [TS];

    int n_checks = 0;
    int n_pass   = 0;

    adder_tree_accumulator #(
        .TREE_STAGES (TS),
        .TREE_W      (TW),
        .ACC_W       (AW),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .tree_advance (tree_advance),
        .tree_result  (tree_result),
        .clear        (clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_chunks   (out_chunks),
        .out_sat      (out_sat)
    );

    // Adder tree stand-in: sum of all inputs, TS advancing edges of latency.
    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < NI; i++) chunk_sum = chunk_sum + TW'(elems[i]);
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TS; k++) tree_p[k] <= '0;
        end else if (tree_advance) begin
            tree_p[0] <= chunk_sum;
            for (int k = 1; k < TS; k++) tree_p[k] <= tree_p[k-1];
        end
    end
    assign tree_result = tree_p[TS-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Reference model: vector totals in acceptance order, saturated at 2^AW-1.
    typedef struct packed {
        logic [AW-1:0] s;
        logic [CW-1:0] c;
        logic          sat;
    } exp_t;

    exp_t exp_q [$];
    int   cur_tot = 0;
    int   cur_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        int   tot;
        if (rst) begin
            cur_tot = 0;
            cur_cnt = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", 32'(out_sum), 32'(e.s));
                    chk("sb_chunks", 32'(out_chunks), 32'(e.c));
                    chk("sb_sat", 32'(out_sat), 32'(e.sat));
                end
            end
            if (clear) begin
                cur_tot = 0;
                cur_cnt = 0;
            end else if (in_valid && in_ready) begin
                tot = cur_tot + int'(chunk_sum);
                cur_cnt++;
                if (in_last) begin
                    e.sat = (tot > (1 << AW) - 1);
                    e.s   = e.sat ? {AW{1'b1}} : AW'(tot);
                    e.c   = CW'(cur_cnt);
                    exp_q.push_back(e);
                    cur_tot = 0;
                    cur_cnt = 0;
                end else begin
                    cur_tot = tot;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sum(input int s);
        int rem;
        rem = s;
        for (int i = 0; i < NI; i++) begin
            elems[i] = (rem > 4095) ? 12'd4095 : 12'(rem);
            rem = (rem > 4095) ? rem - 4095 : 0;
        end
    endtask

    task automatic load_rand();
        for (int i = 0; i < NI; i++) elems[i] = 12'($urandom_range(0, 4095));
    endtask

    task automatic send(input int s, input logic last);
        load_sum(s);
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 80; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("wait_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [TW-1:0] tr_hold;
        int            hits;
        logic [AW-1:0] cap_s;
        logic [CW-1:0] cap_c;
        int            len;
        int            guard;
        logic          accepted;

        load_sum(0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_chunks", 32'(out_chunks), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_tree_advance", 32'(tree_advance), 32'd1);

        // Single chunk of all ones: total lands exactly TS edges after acceptance.
        rst = 1'b0;
        for (int i = 0; i < NI; i++) elems[i] = 12'd1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 1; i < TS; i++) begin
            tick();
            chk("single_early_valid", 32'(out_valid), 32'd0);
        end
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sum", 32'(out_sum), 32'd16);
        chk("single_chunks", 32'(out_chunks), 32'd1);
        chk("single_sat", 32'(out_sat), 32'd0);
        tick();

        // Three chunks back to back produce a single total.
        send(100, 1'b0);
        send(200, 1'b0);
        send(300, 1'b1);
        hits  = 0;
        cap_s = '0;
        cap_c = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) begin
                hits++;
                cap_s = out_sum;
                cap_c = out_chunks;
            end
        end
        chk("three_output_count", 32'(hits), 32'd1);
        chk("three_sum", 32'(cap_s), 32'd600);
        chk("three_chunks", 32'(cap_c), 32'd3);

        // Back-pressure: total 5 is held while 7 waits at the tree tail.
        out_ready = 1'b0;
        send(5, 1'b1);
        send(7, 1'b1);
        tick();
        tick();
        tick();
        chk("hold_first_valid", 32'(out_valid), 32'd1);
        tr_hold = tree_result;
        for (int i = 0; i < 6; i++) begin
            chk("hold_sum", 32'(out_sum), 32'd5);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_tree_frozen", 32'(tree_result), 32'(tr_hold));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("hold_second_valid", 32'(out_valid), 32'd1);
        chk("hold_second_sum", 32'(out_sum), 32'd7);
        tick();
        chk("hold_drained", 32'(out_valid), 32'd0);

        // Saturation at 16 bits, then a clean vector afterwards.
        for (int i = 0; i < 20; i++) send(4095, (i == 19));
        wait_out();
        chk("sat_sum", 32'(out_sum), 32'hFFFF);
        chk("sat_flag", 32'(out_sat), 32'd1);
        chk("sat_chunks", 32'(out_chunks), 32'd20);
        tick();
        send(1, 1'b1);
        wait_out();
        chk("post_sat_sum", 32'(out_sum), 32'd1);
        chk("post_sat_flag", 32'(out_sat), 32'd0);
        tick();

        // Clear with two chunks in flight leaves no residue.
        send(50, 1'b0);
        send(60, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(9, 1'b1);
        wait_out();
        chk("clear_sum", 32'(out_sum), 32'd9);
        chk("clear_chunks", 32'(out_chunks), 32'd1);
        tick();

        // Holes carry random data that must never be summed.
        send(10, 1'b0);
        load_rand();
        in_last = 1'b1;
        tick();
        tick();
        in_last = 1'b0;
        send(20, 1'b1);
        wait_out();
        chk("gap_sum", 32'(out_sum), 32'd30);
        chk("gap_chunks", 32'(out_chunks), 32'd2);
        tick();

        // Reset with a pending total and a chunk in flight.
        out_ready = 1'b0;
        send(33, 1'b1);
        send(40, 1'b0);
        tick();
        tick();
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_out_chunks", 32'(out_chunks), 32'd0);
        chk("mid_rst_out_sat", 32'(out_sat), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        send(3, 1'b1);
        wait_out();
        chk("post_rst_sum", 32'(out_sum), 32'd3);
        chk("post_rst_chunks", 32'(out_chunks), 32'd1);
        tick();

        // Random vectors, holes and back-pressure against the reference model.
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, 5);
            for (int c = 0; c < len; c++) begin
                guard = 0;
                do begin
                    load_rand();
                    in_valid  = ($urandom_range(0, 3) != 0);
                    in_last   = in_valid ? (c == len - 1) : 1'($urandom_range(0, 1));
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    accepted = in_valid && in_ready;
                    @(posedge clk);
                    #1;
                    guard++;
                end while (!accepted && guard < 200);
                if (!accepted) chk("rand_accept_timeout", 32'(accepted), 32'd1);
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
